single_cycle_processor: RTL and testbench

//  Single-cycle LEGv8/ARMv8-subset CPU and top of the processor design: one instruction fetched, decoded, executed and

---
 rtl/single_cycle_processor_pkg.sv | 55 +++++
 rtl/single_cycle_processor_alu.sv | 30 +++
 rtl/single_cycle_processor_state.sv | 82 ++++++++
 rtl/single_cycle_processor.sv | 96 +++++++++
 tb/tb_single_cycle_processor.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/single_cycle_processor_pkg.sv
// Shared definitions for the single-cycle LEGv8 subset core: opcodes, ALU operations
// and instruction field extraction helpers.
package single_cycle_processor_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_LSL, ALU_LSR, ALU_PASSB
  } alu_op_e;

  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[4:0];
  endfunction

  function automatic logic [4:0] f_rn(input logic [31:0] i);
    return i[9:5];
  endfunction

  function automatic logic [5:0] f_shamt(input logic [31:0] i);
    return i[15:10];
  endfunction

  function automatic logic [4:0] f_rm(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [10:0] f_opcode(input logic [31:0] i);
    return i[31:21];
  endfunction

  function automatic logic [63:0] f_daddr(input logic [31:0] i);
    return {{55{i[20]}}, i[20:12]};
  endfunction

  // Branch offsets are returned already scaled to bytes.
  function automatic logic [63:0] f_cb_offset(input logic [31:0] i);
    return {{43{i[23]}}, i[23:5], 2'b00};
  endfunction

  function automatic logic [63:0] f_b_offset(input logic [31:0] i);
    return {{36{i[25]}}, i[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/single_cycle_processor_alu.sv
// 64-bit ALU with wraparound arithmetic, logical shifts and a pass-through used by CBZ.
module scp_alu
  import single_cycle_processor_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [5:0]  shamt,
  input  alu_op_e     op,
  output logic [63:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_ORR:   result = a | b;
      ALU_EOR:   result = a ^ b;
      ALU_LSL:   result = a << shamt;
      ALU_LSR:   result = a >> shamt;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/single_cycle_processor_state.sv
// State-holding units of the core: program counter, register file, instruction and data memories.
// Only the PC is reset; the arrays are expected to be preloaded.
module scp_pc (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] next,
  output logic [63:0] out
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) out <= '0;
    else        out <= next;
  end

endmodule

module scp_registers (
  input  logic        clock,
  input  logic [4:0]  read_reg_1,
  input  logic [4:0]  read_reg_2,
  input  logic [4:0]  write_reg,
  input  logic        write_enable,
  input  logic [63:0] write_data,
  output logic [63:0] Read_data_1,
  output logic [63:0] Read_data_2
);

  logic [63:0] regfile [0:31];

  // X31 is the zero register: it always reads 0 and swallows writes.
  assign Read_data_1 = (read_reg_1 == 5'd31) ? '0 : regfile[read_reg_1];
  assign Read_data_2 = (read_reg_2 == 5'd31) ? '0 : regfile[read_reg_2];

  always_ff @(posedge clock) begin
    if (write_enable && write_reg != 5'd31) regfile[write_reg] <= write_data;
  end

endmodule

module scp_instruction_memory #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);

  logic [31:0] memory [0:WORDS-1];

  assign data = memory[addr];

  // In-system load port; idle in normal operation, contents come from preload.
  always_ff @(posedge clock) begin
    if (load_en) memory[load_addr] <= load_data;
  end

endmodule

module scp_data_memory #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          write_enable,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   write_data,
  output logic [63:0]   read_data
);

  logic [63:0] memory [0:WORDS-1];

  assign read_data = memory[addr];

  always_ff @(posedge clock) begin
    if (write_enable) memory[addr] <= write_data;
  end

endmodule

// File: rtl/single_cycle_processor.sv
// Single-cycle LEGv8 subset CPU: fetch, decode, execute and writeback in one clock.
// uitgang exposes the ALU zero flag of the instruction currently executing.
module single_cycle_processor
  import single_cycle_processor_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic clock,
  input  logic reset,
  output logic uitgang
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] instruction;
  logic [63:0] pc_out, pc_next;
  logic [63:0] read_data_1, read_data_2, alu_b, alu_result, mem_rdata, write_data;
  logic [10:0] opcode;
  logic        is_r, is_ldur, is_stur, is_br, is_cbz, is_b;
  logic        reg_we, mem_we;
  alu_op_e     alu_op;

  scp_pc pc (.clock(clock), .reset(reset), .next(pc_next), .out(pc_out));

  scp_instruction_memory #(.WORDS(IMEM_WORDS), .AW(IAW)) instruction_memory (
    .clock(clock), .load_en(1'b0), .load_addr('0), .load_data('0),
    .addr(pc_out[IAW+1:2]), .data(instruction)
  );

  assign opcode = f_opcode(instruction);
  assign is_cbz = (instruction[31:24] == OP_CBZ);
  assign is_b   = (instruction[31:26] == OP_B);

  always_comb begin
    is_r    = 1'b1;
    is_ldur = 1'b0;
    is_stur = 1'b0;
    is_br   = 1'b0;
    alu_op  = ALU_ADD;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_ORR:  alu_op = ALU_ORR;
      OP_EOR:  alu_op = ALU_EOR;
      OP_LSL:  alu_op = ALU_LSL;
      OP_LSR:  alu_op = ALU_LSR;
      OP_LDUR: begin is_r = 1'b0; is_ldur = 1'b1; end
      OP_STUR: begin is_r = 1'b0; is_stur = 1'b1; end
      OP_BR:   begin is_r = 1'b0; is_br = 1'b1; end
      default: begin
        is_r = 1'b0;
        if (is_cbz) alu_op = ALU_PASSB;
      end
    endcase
  end

  // Writes are suppressed while reset is held so a stalled PC cannot corrupt state.
  assign reg_we = (is_r | is_ldur) & reset;
  assign mem_we = is_stur & reset;

  scp_registers registers (
    .clock(clock),
    .read_reg_1(f_rn(instruction)),
    .read_reg_2(is_r ? f_rm(instruction) : f_rd(instruction)),
    .write_reg(f_rd(instruction)),
    .write_enable(reg_we),
    .write_data(write_data),
    .Read_data_1(read_data_1),
    .Read_data_2(read_data_2)
  );

  assign alu_b = (is_ldur | is_stur) ? f_daddr(instruction) : read_data_2;

  scp_alu alu (
    .a(read_data_1), .b(alu_b), .shamt(f_shamt(instruction)), .op(alu_op),
    .result(alu_result), .zero(uitgang)
  );

  scp_data_memory #(.WORDS(DMEM_WORDS), .AW(DAW)) data_memory (
    .clock(clock), .write_enable(mem_we), .addr(alu_result[DAW+2:3]),
    .write_data(read_data_2), .read_data(mem_rdata)
  );

  assign write_data = is_ldur ? mem_rdata : alu_result;

  always_comb begin
    pc_next = pc_out + 64'd4;
    if (is_br)                pc_next = read_data_1;
    else if (is_b)            pc_next = pc_out + f_b_offset(instruction);
    else if (is_cbz && uitgang) pc_next = pc_out + f_cb_offset(instruction);
  end

endmodule

// File: tb/tb_single_cycle_processor.sv
// Self-checking bench: directed LEGv8 program plus random programs, compared against an
// instruction-level reference model of the architecture.
module tb_single_cycle_processor;

  localparam logic [10:0] ADD_OP  = 11'b10001011000;
  localparam logic [10:0] SUB_OP  = 11'b11001011000;
  localparam logic [10:0] AND_OP  = 11'b10001010000;
  localparam logic [10:0] ORR_OP  = 11'b10101010000;
  localparam logic [10:0] EOR_OP  = 11'b11001010000;
  localparam logic [10:0] LSL_OP  = 11'b11010011011;
  localparam logic [10:0] LSR_OP  = 11'b11010011010;
  localparam logic [10:0] BR_OP   = 11'b11010110000;
  localparam logic [10:0] LDUR_OP = 11'b11111000010;
  localparam logic [10:0] STUR_OP = 11'b11111000000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic uitgang;

  single_cycle_processor #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clock(clock), .reset(reset), .uitgang(uitgang)
  );

  always #10 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [0:63];
  logic [63:0] x    [0:31];
  logic [63:0] m    [0:63];
  logic [63:0] mpc;
  logic        mzero;
  bit          zvalid;
  logic [10:0] rops [0:6] = '{ADD_OP, SUB_OP, AND_OP, ORR_OP, EOR_OP, LSL_OP, LSR_OP};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] encR(input logic [10:0] op, input int rm, input int sh,
                                       input int rn, input int rd);
    return {op, 5'(rm), 6'(sh), 5'(rn), 5'(rd)};
  endfunction

  function automatic logic [31:0] encD(input logic [10:0] op, input int off, input int rn, input int rt);
    return {op, 9'(off), 2'b00, 5'(rn), 5'(rt)};
  endfunction

  function automatic logic [31:0] encCbz(input int off, input int rt);
    return {8'hB4, 19'(off), 5'(rt)};
  endfunction

  function automatic logic [31:0] encB(input int off);
    return {6'b000101, 26'(off)};
  endfunction

  function automatic logic [63:0] rv(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : x[r];
  endfunction

  // Executes one instruction architecturally: registers, memory and PC.
  task automatic modelStep();
    logic [31:0] ins;
    logic [63:0] a, b, res, addr, nxt;
    logic [4:0]  rd;
    bit          wr;
    ins    = prog[mpc[7:2]];
    rd     = ins[4:0];
    a      = rv(ins[9:5]);
    b      = rv(ins[20:16]);
    addr   = a + longint'($signed(ins[20:12]));
    nxt    = mpc + 64'd4;
    res    = 64'd0;
    wr     = 1'b1;
    zvalid = 1'b1;
    case (ins[31:21])
      ADD_OP: res = a + b;
      SUB_OP: res = a - b;
      AND_OP: res = a & b;
      ORR_OP: res = a | b;
      EOR_OP: res = a ^ b;
      LSL_OP: res = a << ins[15:10];
      LSR_OP: res = a >> ins[15:10];
      LDUR_OP: begin wr = 1'b0; zvalid = 1'b0; if (rd != 5'd31) x[rd] = m[addr[8:3]]; end
      STUR_OP: begin wr = 1'b0; zvalid = 1'b0; m[addr[8:3]] = rv(rd); end
      BR_OP:   begin wr = 1'b0; zvalid = 1'b0; nxt = a; end
      default: begin
        wr = 1'b0;
        zvalid = 1'b0;
        if (ins[31:24] == 8'hB4) begin
          zvalid = 1'b1;
          res = rv(rd);
          if (res == 64'd0) nxt = mpc + longint'($signed(ins[23:5])) * 4;
        end else if (ins[31:26] == 6'b000101) begin
          nxt = mpc + longint'($signed(ins[25:0])) * 4;
        end
      end
    endcase
    if (wr && rd != 5'd31) x[rd] = res;
    mzero = (res == 64'd0);
    mpc   = nxt;
  endtask

  // Each cycle: compare combinational view before the edge, then advance the model.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      checkOutput("pc", dut.pc.out, mpc);
      checkOutput("x2", dut.registers.regfile[2], x[2]);
      modelStep();
      if (zvalid) checkOutput("uitgang", 64'(uitgang), 64'(mzero));
    end
  endtask

  task automatic checkState(input string tag);
    @(posedge clock);
    #1;
    checkOutput({tag, "_pc"}, dut.pc.out, mpc);
    for (int r = 0; r < 31; r++)
      checkOutput($sformatf("%s_x%0d", tag, r), dut.registers.regfile[r], x[r]);
    for (int i = 0; i < 64; i++)
      checkOutput($sformatf("%s_m%0d", tag, i), dut.data_memory.memory[i], m[i]);
  endtask

  task automatic loadDut();
    for (int i = 0; i < 64; i++) begin
      dut.instruction_memory.memory[i] = prog[i];
      dut.data_memory.memory[i] = m[i];
    end
    for (int r = 0; r < 32; r++) dut.registers.regfile[r] = x[r];
    mpc = 64'd0;
  endtask

  function automatic logic [31:0] randInstr();
    int rd, rn, rm;
    rd = $urandom_range(0, 31);
    rn = $urandom_range(0, 31);
    rm = $urandom_range(0, 31);
    case ($urandom_range(0, 12))
      0, 1, 2, 3, 4, 5, 6: return encR(rops[$urandom_range(0, 6)], rm, $urandom_range(0, 63), rn, rd);
      7:  return encD(LDUR_OP, $urandom_range(0, 511), rn, rd);
      8:  return encD(STUR_OP, $urandom_range(0, 511), rn, rd);
      9:  return encCbz(int'($urandom_range(0, 16)) - 8, rd);
      10: return encB(int'($urandom_range(0, 16)) - 8);
      11: return encR(BR_OP, 0, 0, rn, 0);
      default: return $urandom;
    endcase
  endfunction

  int exp_x2 [0:6] = '{26, 14, 4, 22, 18, 160, 2};

  initial begin
    for (int i = 0; i < 64; i++) begin prog[i] = 32'd0; m[i] = 64'd0; end
    for (int r = 0; r < 32; r++) x[r] = 64'd0;
    x[16] = 64'd20; x[17] = 64'd8; x[18] = 64'd6;
    prog[0]  = encR(ADD_OP, 18, 0, 16, 2);
    prog[1]  = encR(SUB_OP, 18, 0, 16, 2);
    prog[2]  = encR(AND_OP, 18, 0, 16, 2);
    prog[3]  = encR(ORR_OP, 18, 0, 16, 2);
    prog[4]  = encR(EOR_OP, 18, 0, 16, 2);
    prog[5]  = encR(LSL_OP, 0, 3, 16, 2);
    prog[6]  = encR(LSR_OP, 0, 3, 16, 2);
    prog[7]  = encD(STUR_OP, 8, 31, 16);
    prog[8]  = encD(LDUR_OP, 8, 31, 3);
    prog[9]  = encCbz(2, 31);
    prog[10] = encR(ADD_OP, 31, 0, 31, 2);
    prog[11] = encR(SUB_OP, 16, 0, 16, 2);
    prog[12] = encR(BR_OP, 0, 0, 17, 0);
    loadDut();
    #1;
    checkOutput("reset_pc", dut.pc.out, 64'd0);
    #14 reset = 1'b1;

    for (int k = 0; k < 7; k++) begin
      if (k < 2) checkOutput("dir_uitgang_low", 64'(uitgang), 64'd0);
      if (k >= 2 && k <= 4) begin
        checkOutput("dir_rd1", dut.registers.Read_data_1, 64'd20);
        checkOutput("dir_rd2", dut.registers.Read_data_2, 64'd6);
      end
      applyStimulus(1);
      @(posedge clock);
      #1;
      checkOutput($sformatf("dir_x2_%0d", k), dut.registers.regfile[2], 64'(exp_x2[k]));
    end
    applyStimulus(2);
    @(posedge clock); #1;
    checkOutput("dir_ldur_x3", dut.registers.regfile[3], 64'd20);
    applyStimulus(1);
    @(posedge clock); #1;
    checkOutput("dir_cbz_pc", dut.pc.out, 64'd44);
    checkOutput("dir_sub_zero", 64'(uitgang), 64'd1);
    applyStimulus(1);
    @(posedge clock); #1;
    checkOutput("dir_sub_x2", dut.registers.regfile[2], 64'd0);
    applyStimulus(1);
    @(posedge clock); #1;
    checkOutput("dir_br_pc", dut.pc.out, 64'd8);
    applyStimulus(11);
    @(posedge clock); #1;
    checkOutput("dir_loop_x2", dut.registers.regfile[2], 64'd4);

    reset = 1'b0;
    #1;
    checkOutput("mid_reset_pc", dut.pc.out, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("mid_reset_pc_hold", dut.pc.out, 64'd0);
    checkOutput("mid_reset_x2", dut.registers.regfile[2], x[2]);
    @(posedge clock); #1 reset = 1'b1;
    mpc = 64'd0;
    applyStimulus(5);
    checkState("dir");

    for (int n = 0; n < 3; n++) begin
      reset = 1'b0;
      for (int i = 0; i < 64; i++) begin
        prog[i] = randInstr();
        m[i] = {$urandom, $urandom};
      end
      for (int r = 0; r < 32; r++)
        x[r] = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      loadDut();
      @(posedge clock); #1 reset = 1'b1;
      applyStimulus(300);
      checkState($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
